// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU command sequencer.
package alu_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } seq_state_e;

   // Opcodes, in the same order as the ALU result-mux select inputs
   localparam logic [2:0] OP_0 = 3'b000;
   localparam logic [2:0] OP_1 = 3'b001;
   localparam logic [2:0] OP_2 = 3'b010;
   localparam logic [2:0] OP_3 = 3'b011;
   localparam logic [2:0] OP_4 = 3'b100;
   localparam logic [2:0] OP_5 = 3'b101;
   localparam logic [2:0] OP_6 = 3'b110;
   localparam logic [2:0] OP_7 = 3'b111;

   // Clamp a sign-extended value into the signed n-bit range
   // [-2^(n-1), 2^(n-1)-1]; callers keep the low n bits.
   function automatic logic signed [31:0] sat_n(input logic signed [31:0] v, input int n);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (n - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (n - 1));
      if (v > hi) begin
         sat_n = hi;
      end else if (v < lo) begin
         sat_n = lo;
      end else begin
         sat_n = v;
      end
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries, pointers carry an extra wrap bit so that
// full and empty can be told apart without a separate counter.
// rdata_o always shows the head entry (first-word fall-through).
module alu_cmd_fifo #(
   parameter int W     = 15,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q;
   logic [AW:0]  rd_ptr_q;
   logic         do_push;
   logic         do_pop;

   // Ignore pushes when full and pops when empty so the pointers never cross
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; push and pop in the same cycle both take effect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-level controller for the multifunction ALU. Buffers requests,
// issues them one at a time to the datapath, waits LAT cycles and returns
// the captured result.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. cmd_ready depends only on FIFO fullness; rsp_valid, once high,
// holds rsp_res/rsp_op stable until the edge on which rsp_ready is seen.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int LAT   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic signed [N-1:0] cmd_a,
   input  logic signed [N-1:0] cmd_b,
   input  logic                cmd_chain,
   output logic signed [N-1:0] alu_a,
   output logic signed [N-1:0] alu_b,
   output logic [2:0]          alu_sel,
   input  logic signed [N+1:0] alu_res,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic signed [N+1:0] rsp_res,
   output logic [2:0]          rsp_op,
   output logic                busy,
   output seq_state_e          dbg_state
);

   localparam int         FW       = 1 + 3 + 2 * N;
   localparam logic [2:0] LAT_INIT = 3'(LAT);

   seq_state_e          state_q;
   logic [2:0]          lat_cnt_q;
   logic signed [N-1:0] alu_a_q;
   logic signed [N-1:0] alu_b_q;
   logic [2:0]          alu_sel_q;
   logic                rsp_valid_q;
   logic signed [N+1:0] rsp_res_q;
   logic [2:0]          rsp_op_q;
   logic signed [N+1:0] last_res_q;

   logic [FW-1:0]       fifo_wdata;
   logic [FW-1:0]       fifo_rdata;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;

   logic                head_chain;
   logic [2:0]          head_op;
   logic signed [N-1:0] head_a;
   logic signed [N-1:0] head_b;
   logic signed [N-1:0] sat_a;
   logic signed [N-1:0] issue_a_d;

   assign cmd_ready  = !fifo_full;
   assign fifo_wdata = {cmd_chain, cmd_op, cmd_a, cmd_b};
   assign {head_chain, head_op, head_a, head_b} = fifo_rdata;

   alu_cmd_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_valid && cmd_ready),
      .pop_i   (pop),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Saturated previous result, used as operand A for chained commands
   assign sat_a = N'(sat_n({{(30-N){last_res_q[N+1]}}, last_res_q}, N));

   // Pop decision and operand A selection for the command about to issue
   always_comb begin
      pop       = 1'b0;
      issue_a_d = head_a;
      if (!fifo_empty) begin
         if (state_q == IDLE) pop = 1'b1;
         if (state_q == HOLD && rsp_ready) pop = 1'b1;
      end
      if (head_chain) issue_a_d = sat_a;
   end

   // Sequencer FSM with latency counter, issue and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lat_cnt_q   <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= OP_0;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= '0;
         rsp_op_q    <= OP_0;
         last_res_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  alu_a_q   <= issue_a_d;
                  alu_b_q   <= head_b;
                  alu_sel_q <= head_op;
                  lat_cnt_q <= LAT_INIT;
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               lat_cnt_q <= lat_cnt_q - 3'd1;
               if (lat_cnt_q == 3'd1) begin
                  rsp_res_q   <= alu_res;
                  last_res_q  <= alu_res;
                  rsp_op_q    <= alu_sel_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  if (pop) begin
                     alu_a_q   <= issue_a_d;
                     alu_b_q   <= head_b;
                     alu_sel_q <= head_op;
                     lat_cnt_q <= LAT_INIT;
                     state_q   <= EXEC;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_res   = rsp_res_q;
   assign rsp_op    = rsp_op_q;
   assign busy      = (state_q != IDLE) || !fifo_empty;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer (N=4, DEPTH=4, LAT=1) with a behavioural
// datapath stand-in and an in-order result model.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int N = 4;
   localparam int W = 3 + N + 2;

   logic                clk;
   logic                rst_n;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [2:0]          cmd_op;
   logic signed [N-1:0] cmd_a;
   logic signed [N-1:0] cmd_b;
   logic                cmd_chain;
   logic signed [N-1:0] alu_a;
   logic signed [N-1:0] alu_b;
   logic [2:0]          alu_sel;
   logic signed [N+1:0] alu_res;
   logic                rsp_valid;
   logic                rsp_ready;
   logic signed [N+1:0] rsp_res;
   logic [2:0]          rsp_op;
   logic                busy;
   seq_state_e          dbg_state;

   int checks;
   int errors;
   int m_last;
   logic [W-1:0] exp_q[$];

   alu_op_sequencer #(.N(N), .DEPTH(4), .LAT(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_chain (cmd_chain),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_res   (alu_res),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_op    (rsp_op),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- datapath stand-in ----------------
   function automatic logic signed [N+1:0] alu_fn(input logic [2:0] op,
                                                  input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
      int ai;
      int bi;
      int r;
      ai = a;
      bi = b;
      case (op)
         3'd0:    r = ai - bi;
         3'd1:    r = ai & bi;
         3'd2:    r = ai + bi;
         3'd3:    r = ai | bi;
         3'd4:    r = ai ^ bi;
         3'd5:    r = -ai;
         3'd6:    r = ai * 2;
         default: r = bi;
      endcase
      return (N+2)'(r);
   endfunction

   assign alu_res = alu_fn(alu_sel, alu_a, alu_b);

   // ---------------- model ----------------
   function automatic logic signed [N-1:0] sat4(input int v);
      if (v > 7) return 4'sd7;
      if (v < -8) return -4'sd8;
      return N'(v);
   endfunction

   task automatic model_push(input logic [2:0] op, input logic signed [N-1:0] a,
                             input logic signed [N-1:0] b, input logic chain);
      logic signed [N-1:0] a_eff;
      logic signed [N+1:0] r;
      a_eff  = chain ? sat4(m_last) : a;
      r      = alu_fn(op, a_eff, b);
      m_last = r;
      exp_q.push_back({op, r});
   endtask

   task automatic model_flush();
      exp_q.delete();
      m_last = 0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_timeout(input string name, input int n, input int limit);
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
      end
   endtask

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic push_cmd(input logic [2:0] op, input logic signed [N-1:0] a,
                           input logic signed [N-1:0] b, input logic chain);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_chain = chain;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk_timeout("push_wait", n, 100);
         cmd_valid = 1'b0;
      end else begin
         model_push(op, a, b, chain);
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      rsp_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk_timeout("drain", n, 300);
      chk("busy_after_drain", busy, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus tables ----------------
   logic [2:0]          fill_op [5] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
   logic signed [N-1:0] fill_a  [5] = '{4'sd5, -4'sd4, 4'sd6, -4'sd7, -4'sd5};
   logic signed [N-1:0] fill_b  [5] = '{4'sd3, 4'sd2, -4'sd1, 4'sd0, 4'sd4};
   logic signed [N-1:0] ch_a    [3] = '{4'sd7, -4'sd8, 4'sd2};
   logic signed [N-1:0] ch_b    [3] = '{-4'sd6, 4'sd3, -4'sd3};
   int                  ch_exp  [3] = '{7, -8, 5};

   initial begin
      logic [W-1:0]        e;
      logic signed [N+1:0] er;
      checks    = 0;
      errors    = 0;
      m_last    = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_chain = 1'b0;
      rsp_ready = 1'b0;

      // response compare: every accepted response against the model queue
      fork
         forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected: got res %0d op %0d, required none", rsp_res, rsp_op);
               end else begin
                  e  = exp_q.pop_front();
                  er = e[N+1:0];
                  chk("rsp_op", rsp_op, e[W-1:N+2]);
                  chk("rsp_res", rsp_res, er);
               end
            end
         end
      join_none

      // ---- reset values ----
      step();
      step();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_rsp_op", rsp_op, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dbg_state, IDLE);
      rst_n = 1'b1;
      step();

      // ---- single command: op=010, a=3, b=-2 -> 1 ----
      push_cmd(3'b010, 4'sd3, -4'sd2, 1'b0);
      step();
      chk("t1_alu_sel", alu_sel, 2);
      chk("t1_alu_a", alu_a, 3);
      chk("t1_alu_b", alu_b, -2);
      chk("t1_rsp_valid_early", rsp_valid, 0);
      chk("t1_busy", busy, 1);
      step();
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_res", rsp_res, 1);
      chk("t1_rsp_op", rsp_op, 2);
      drain();

      // ---- fill with rsp_ready low: 1 in flight + 4 queued ----
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_cmd(fill_op[i], fill_a[i], fill_b[i], 1'b0);
         if (i == 3) chk("fill_ready_at3", cmd_ready, 1);
         if (i == 4) begin
            chk("fill_ready_full", cmd_ready, 0);
            chk("fill_busy", busy, 1);
         end
      end
      step();
      chk("fill_hold_stable", rsp_valid, 1);
      drain();

      // ---- chaining with saturation, back-to-back issue ----
      for (int i = 0; i < 3; i++) begin
         push_cmd(3'd0, ch_a[i], ch_b[i], 1'b0);
         push_cmd(3'd0, 4'sd3, 4'sd1, 1'b1);
         step();
         chk("b2b_valid_1", rsp_valid, 1);
         step();
         chk("chain_alu_a", alu_a, ch_exp[i]);
         chk("chain_alu_b", alu_b, 1);
         chk("b2b_gap_low", rsp_valid, 0);
         chk("b2b_state_exec", dbg_state, EXEC);
         step();
         chk("b2b_valid_2", rsp_valid, 1);
         drain();
      end

      // ---- reset during EXEC with 3 queued ----
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_cmd(fill_op[i], fill_a[i], fill_b[i], 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("mid_state_exec", dbg_state, EXEC);
      chk("mid_full_after_pop", cmd_ready, 1);
      rst_n = 1'b0;
      #1;
      model_flush();
      chk("mrst_rsp_valid", rsp_valid, 0);
      chk("mrst_rsp_res", rsp_res, 0);
      chk("mrst_alu_a", alu_a, 0);
      chk("mrst_alu_sel", alu_sel, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_cmd_ready", cmd_ready, 1);
      step();
      step();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("post_rst_rsp_valid", rsp_valid, 0);
      end
      chk("post_rst_busy", busy, 0);

      // ---- simultaneous push and pop at count 2 ----
      rsp_ready = 1'b0;
      push_cmd(3'd2, 4'sd1, 4'sd1, 1'b0);
      push_cmd(3'd3, 4'sd4, 4'sd1, 1'b0);
      push_cmd(3'd7, 4'sd0, -4'sd5, 1'b0);
      rsp_ready = 1'b1;
      push_cmd(3'd4, 4'sd5, 4'sd3, 1'b0);
      rsp_ready = 1'b0;
      push_cmd(3'd1, -4'sd1, 4'sd6, 1'b0);
      chk("pp_ready_count3", cmd_ready, 1);
      push_cmd(3'd0, 4'sd2, -4'sd4, 1'b0);
      chk("pp_ready_count4", cmd_ready, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
